// File: rtl/jt49_bus_arb.sv
// -----------------------------------------------------------------------------
// jt49_bus_arb
// Two-requester arbiter and bus sequencer for a JT49/AY-3-8910 style PSG.
// Each accepted access runs one complete PSG bus cycle, then the arbiter
// returns to IDLE before it accepts the next access.
//   IDLE -> SETUP -> STROBE (HOLD cycles)   -> RECOVER -> IDLE   (write)
//   IDLE -> SETUP -> RDWAIT (2 cycles)      -> RECOVER -> IDLE   (read)
// RECOVER deasserts cs_n/wr_n between accesses. Every write therefore has its
// own wr_n falling edge, so writes to register 13 retrigger the envelope.
//
// Parameters
//   HOLD            cycles psg_wr_n is held low per write (legal 1..15)
// Build options
//   JT49_ARB_RR_EN  defined: round-robin between requesters.
//                   undefined: requester 0 has fixed priority.
//
// Ports
//   clk, rst_n                      clock; asynchronous active-low reset
//   reqN_valid/ready                request handshake (N = 0,1)
//   reqN_we/addr/wdata              access type, register index, write data
//   rspN_valid/rdata                one-cycle read-response pulse, held data
//   psg_addr/din/cs_n/wr_n          bus outputs to the PSG
//   psg_dout                        registered read data from the PSG
//   busy                            high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module jt49_bus_arb #(
    parameter int HOLD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic       req0_we,
    input  logic [3:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       rsp0_valid,
    output logic [7:0] rsp0_rdata,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic       req1_we,
    input  logic [3:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       rsp1_valid,
    output logic [7:0] rsp1_rdata,
    output logic [3:0] psg_addr,
    output logic [7:0] psg_din,
    output logic       psg_cs_n,
    output logic       psg_wr_n,
    input  logic [7:0] psg_dout,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_RDWAIT  = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_CNT = 4'(HOLD);
    localparam logic [3:0] RD_CNT   = 4'd2;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;

    logic       r_we;
    logic       r_id;       // requester that owns the in-flight access
    logic       r_last;     // requester granted most recently
    logic [3:0] r_addr;
    logic [7:0] r_din;
    logic       r_rsp0_valid;
    logic       r_rsp1_valid;
    logic [7:0] r_rsp0_rdata;
    logic [7:0] r_rsp1_rdata;

    logic       w_idle;
    logic       w_pick1;
    logic       w_accept;
    logic       w_rd_done;

    assign w_idle = (r_state == S_IDLE);

    // w_pick1: requester 1 wins when it is the only one valid, or (round-robin)
    // when both are valid and requester 0 was served last.
`ifdef JT49_ARB_RR_EN
    assign w_pick1 = req1_valid & (~req0_valid | ~r_last);
`else
    logic w_last_unused;
    assign w_last_unused = r_last;
    assign w_pick1       = req1_valid & ~req0_valid;
`endif

    assign req0_ready = w_idle & req0_valid & ~w_pick1;
    assign req1_ready = w_idle & w_pick1;
    assign w_accept   = w_idle & (req0_valid | req1_valid);

    // The response is captured on the edge that leaves RDWAIT.
    assign w_rd_done  = (r_state == S_RDWAIT) && (r_cnt == 4'd1);

    // Strobes decode straight from the state register. The async reset then
    // releases them without waiting for a clock edge.
    assign psg_cs_n   = ~((r_state == S_SETUP) || (r_state == S_STROBE) ||
                          (r_state == S_RDWAIT));
    assign psg_wr_n   = ~(r_state == S_STROBE);
    assign busy       = ~w_idle;
    assign psg_addr   = r_addr;
    assign psg_din    = r_din;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_we) begin
                    w_state_next = S_STROBE;
                    w_cnt_next   = HOLD_CNT;
                end else begin
                    w_state_next = S_RDWAIT;
                    w_cnt_next   = RD_CNT;
                end
            end
            S_STROBE, S_RDWAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_next = S_RECOVER;
                    w_cnt_next   = 4'd0;
                end else begin
                    w_cnt_next   = r_cnt - 4'd1;
                end
            end
            S_RECOVER: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_we         <= 1'b0;
            r_id         <= 1'b0;
            r_last       <= 1'b1;
            r_addr       <= 4'd0;
            r_din        <= 8'd0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= 8'd0;
            r_rsp1_rdata <= 8'd0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_rsp0_valid <= w_rd_done & ~r_id;
            r_rsp1_valid <= w_rd_done & r_id;
            if (w_accept) begin
                r_id   <= w_pick1;
                r_last <= w_pick1;
                r_we   <= w_pick1 ? req1_we    : req0_we;
                r_addr <= w_pick1 ? req1_addr  : req0_addr;
                r_din  <= w_pick1 ? req1_wdata : req0_wdata;
            end
            if (w_rd_done && !r_id) begin
                r_rsp0_rdata <= psg_dout;
            end
            if (w_rd_done && r_id) begin
                r_rsp1_rdata <= psg_dout;
            end
        end
    end

endmodule
